multibyte_addsub_seq: RTL and testbench
=======================================

Name: multibyte_addsub_seq

Overview:
- Sequencer that sits directly upstream of the 8-bit ripple subtract/add stage and consumes that stage's output.
- Performs NBYTES-wide add or subtract by driving the 8-bit stage one byte per cycle, LSB first.
- Chains the borrow/carry-out of each byte into the next byte's B_CIN.
- Assembles the wide result and reports carry/borrow, zero and signed-overflow flags with a start/done handshake.

Parameters:
NBYTES, 4, operand width in bytes (>=1); datapath width W = 8*NBYTES

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
START  input  1  request; sampled only in IDLE
SUB_ADD  input  1  1 = A-B (borrow chain), 0 = A+B (carry chain); captured with START
OP_A  input  W  minuend/addend; captured with START
OP_B  input  W  subtrahend/addend; captured with START
ADD_A  output  8  byte of captured A for the 8-bit stage
ADD_B  output  8  byte of captured B for the 8-bit stage
ADD_BCIN  output  1  chain bit into the 8-bit stage
ADD_SUB_ADD  output  1  captured SUB_ADD to the 8-bit stage
ADD_DS  input  8  difference/sum from the 8-bit stage (combinational, same cycle)
ADD_BCOUT  input  1  borrow/carry-out from the 8-bit stage
RESULT  output  W  final difference/sum
BC_OUT  output  1  final borrow (sub) or carry (add)
ZERO  output  1  RESULT == 0
OVF  output  1  signed two's-complement overflow
BUSY  output  1  operation in progress
DONE  output  1  one-cycle pulse; RESULT and flags updated

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE; all outputs 0; internal operand, index, chain and partial-result registers 0.
  - Takes effect immediately, including mid-operation; the aborted operation never pulses DONE.
- States: IDLE, RUN.
- IDLE:
  - BUSY=0; ADD_A, ADD_B, ADD_BCIN and ADD_SUB_ADD drive 0.
  - START=1 at edge k: capture OP_A, OP_B, SUB_ADD; idx<=0; chain<=0; BUSY<=1; go RUN.
- RUN, combinational drive:
  - ADD_A = A_cap[8*idx+7:8*idx]; ADD_B = B_cap byte idx.
  - ADD_BCIN = chain; ADD_SUB_ADD = SUB_cap.
- RUN, each edge:
  - partial byte idx <= ADD_DS; chain <= ADD_BCOUT; idx <= idx+1.
  - At the edge where idx==NBYTES-1 (edge k+NBYTES), the following update together:
    - RESULT <= {ADD_DS, partial[lower bytes]}
    - BC_OUT <= ADD_BCOUT
    - ZERO <= (assembled result == 0)
    - OVF <= overflow term (below)
    - DONE <= 1, BUSY <= 0, state <= IDLE
- Overflow term:
  - Add: OVF = (A_cap[W-1]==B_cap[W-1]) && (R[W-1]!=A_cap[W-1]).
  - Sub: OVF = (A_cap[W-1]!=B_cap[W-1]) && (R[W-1]!=A_cap[W-1]).
- DONE:
  - High exactly one cycle.
  - Deasserts at the next edge unless that edge also completes an operation (NBYTES=1 back-to-back).
- Latency: START edge to DONE/RESULT edge = NBYTES cycles; BUSY high for exactly NBYTES cycles.
- Output holding: RESULT, BC_OUT, ZERO and OVF hold their values until the next completion; they do not change when START is accepted.
- Simultaneous events:
  - START while BUSY=1 is ignored; no queueing.
  - Changes on OP_A, OP_B or SUB_ADD during RUN have no effect.
  - START in the DONE cycle is accepted, since state is already IDLE (back-to-back throughput = NBYTES cycles per op).
- Width rules:
  - No sign extension; the chain is unsigned.
  - The first byte's chain-in is always 0.
  - Index counter width = max(1, clog2(NBYTES)); idx wraps to 0 on completion.
- NBYTES=1: single RUN cycle; DONE at edge k+1.

Test Plan (NBYTES=4):
1. Carry into byte 1: add 0x000000FF+0x00000001 -> RESULT=0x00000100, BC_OUT=0, ZERO=0, OVF=0; DONE exactly 4 cycles after START edge, BUSY high 4 cycles; ADD_BCIN=1 on the idx=1 cycle.
2. Full borrow chain: sub 0x00000000-0x00000001 -> RESULT=0xFFFFFFFF, BC_OUT=1, OVF=0, ZERO=0.
3. Signed overflow and full carry: add 0x7FFFFFFF+0x00000001 -> 0x80000000, OVF=1, BC_OUT=0; then add 0xFFFFFFFF+0x00000001 -> RESULT=0, BC_OUT=1, ZERO=1, OVF=0.
4. Zero result and subtract overflow: sub 0x12345678-0x12345678 -> 0, BC_OUT=0, ZERO=1; then sub 0x80000000-0x00000001 -> 0x7FFFFFFF, OVF=1, BC_OUT=0.
5. Handshake: pulse START during BUSY with different operands -> ignored, first result intact; assert START on the DONE cycle -> second op accepted, second DONE 4 cycles later.
6. Reset mid-operation: RST_N low 2 cycles after START -> all outputs 0 asynchronously (before next edge), no DONE; after release, a fresh op completes correctly.

Source files
------------

// File: rtl/multibyte_addsub_seq.sv
// Byte-serial wide add/subtract sequencer driving an external 8-bit
// ripple add/sub stage, LSB byte first, with carry/borrow chaining.
// Ports:
//   CLK, RST_N                 clock, async active-low reset
//   START, SUB_ADD, OP_A, OP_B request and operands (sampled in IDLE)
//   ADD_A, ADD_B, ADD_BCIN,
//   ADD_SUB_ADD                combinational drive to the 8-bit stage
//   ADD_DS, ADD_BCOUT          same-cycle result from the 8-bit stage
//   RESULT, BC_OUT, ZERO, OVF  registered final result and flags
//   BUSY, DONE                 handshake (DONE is a one-cycle pulse)
module multibyte_addsub_seq #(
  parameter int unsigned NBYTES = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  input  logic                  SUB_ADD,
  input  logic [8*NBYTES-1:0]   OP_A,
  input  logic [8*NBYTES-1:0]   OP_B,
  output logic [7:0]            ADD_A,
  output logic [7:0]            ADD_B,
  output logic                  ADD_BCIN,
  output logic                  ADD_SUB_ADD,
  input  logic [7:0]            ADD_DS,
  input  logic                  ADD_BCOUT,
  output logic [8*NBYTES-1:0]   RESULT,
  output logic                  BC_OUT,
  output logic                  ZERO,
  output logic                  OVF,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int unsigned W    = 8 * NBYTES;
  localparam int unsigned IW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          sub_q, sub_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          chain_q, chain_d;
  logic [W-1:0]  part_q, part_d;
  logic [W-1:0]  result_q, result_d;
  logic          bc_q, bc_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic [7:0]    a_byte, b_byte;
  logic [W-1:0]  assembled;
  logic          res_msb;

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      idx_q    <= '0;
      chain_q  <= 1'b0;
      part_q   <= '0;
      result_q <= '0;
      bc_q     <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      idx_q    <= idx_d;
      chain_q  <= chain_d;
      part_q   <= part_d;
      result_q <= result_d;
      bc_q     <= bc_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  // Select the current operand bytes and splice the stage output into the partial result
  always_comb begin
    a_byte    = '0;
    b_byte    = '0;
    assembled = part_q;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx_q == IW'(i)) begin
        a_byte               = a_q[8*i +: 8];
        b_byte               = b_q[8*i +: 8];
        assembled[8*i +: 8]  = ADD_DS;
      end
    end
  end

  // On the last byte ADD_DS is the result's top byte
  assign res_msb = ADD_DS[7];

  // Next-state, datapath update and stage drive
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    idx_d       = idx_q;
    chain_d     = chain_q;
    part_d      = part_q;
    result_d    = result_q;
    bc_d        = bc_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ADD_A       = '0;
    ADD_B       = '0;
    ADD_BCIN    = 1'b0;
    ADD_SUB_ADD = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          a_d     = OP_A;
          b_d     = OP_B;
          sub_d   = SUB_ADD;
          idx_d   = '0;
          chain_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        ADD_A       = a_byte;
        ADD_B       = b_byte;
        ADD_BCIN    = chain_q;
        ADD_SUB_ADD = sub_q;
        part_d      = assembled;
        chain_d     = ADD_BCOUT;
        idx_d       = idx_q + IW'(1);
        if (idx_q == LAST) begin
          idx_d    = '0;
          result_d = assembled;
          bc_d     = ADD_BCOUT;
          zero_d   = (assembled == '0);
          // Subtract overflows when operand signs differ, add when they match
          ovf_d    = ((a_q[W-1] ^ b_q[W-1]) == sub_q) && (res_msb != a_q[W-1]);
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign RESULT = result_q;
  assign BC_OUT = bc_q;
  assign ZERO   = zero_q;
  assign OVF    = ovf_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;

endmodule

// File: tb/tb_multibyte_addsub_seq.sv
// Bench for multibyte_addsub_seq (NBYTES=4): provides the 8-bit add/sub
// stage, keeps a whole-word arithmetic model checked every cycle, and runs
// directed operations with hand-computed expectations.
module tb_multibyte_addsub_seq;

  localparam int unsigned NB = 4;
  localparam int unsigned W  = 8 * NB;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          sub_add;
  logic [W-1:0]  op_a, op_b;
  logic [7:0]    add_a, add_b, add_ds;
  logic          add_bcin, add_sub_add, add_bcout;
  logic [W-1:0]  result;
  logic          bc_out, zero, ovf, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  multibyte_addsub_seq #(.NBYTES(NB)) dut (
    .CLK(clk), .RST_N(rst_n), .START(start), .SUB_ADD(sub_add),
    .OP_A(op_a), .OP_B(op_b),
    .ADD_A(add_a), .ADD_B(add_b), .ADD_BCIN(add_bcin), .ADD_SUB_ADD(add_sub_add),
    .ADD_DS(add_ds), .ADD_BCOUT(add_bcout),
    .RESULT(result), .BC_OUT(bc_out), .ZERO(zero), .OVF(ovf),
    .BUSY(busy), .DONE(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // 8-bit ripple stage: 9-bit arithmetic, bit 8 is the carry or borrow
  logic [8:0] stage_r;
  always_comb begin
    if (add_sub_add) stage_r = 9'(add_a) - 9'(add_b) - 9'(add_bcin);
    else             stage_r = 9'(add_a) + 9'(add_b) + 9'(add_bcin);
  end
  assign add_ds    = stage_r[7:0];
  assign add_bcout = stage_r[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- whole-word reference model ----------------
  logic          m_busy = 1'b0;
  logic          m_done = 1'b0;
  int            m_cnt  = 0;
  logic [W-1:0]  m_a = '0, m_b = '0;
  logic          m_sub = 1'b0;
  logic [W-1:0]  m_res = '0;
  logic          m_bc = 1'b0, m_zero = 1'b0, m_ovf = 1'b0;

  // Carry/borrow entering byte i, from the arithmetic of the lower i bytes
  function automatic logic chain_in(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic sub, input int i);
    longint unsigned mask, la, lb;
    if (i == 0) return 1'b0;
    mask = (64'd1 << (8 * i)) - 64'd1;
    la = 64'(a) & mask;
    lb = 64'(b) & mask;
    if (sub) return la < lb;
    return 1'(((la + lb) >> (8 * i)) & 64'd1);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0; m_done = 1'b0; m_cnt = 0;
      m_a = '0; m_b = '0; m_sub = 1'b0;
      m_res = '0; m_bc = 1'b0; m_zero = 1'b0; m_ovf = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_cnt++;
        if (m_cnt == NB) begin
          longint sa, sb, t;
          sa = longint'($signed(m_a));
          sb = longint'($signed(m_b));
          t  = m_sub ? sa - sb : sa + sb;
          if (m_sub) begin
            m_res = m_a - m_b;
            m_bc  = (m_a < m_b);
          end else begin
            m_res = W'((64'(m_a) + 64'(m_b)));
            m_bc  = 1'(((64'(m_a) + 64'(m_b)) >> W) & 64'd1);
          end
          m_zero = (m_res == '0);
          m_ovf  = (t > 64'sd2147483647) || (t < -64'sd2147483648);
          m_busy = 1'b0;
          m_done = 1'b1;
          m_cnt  = 0;
        end
      end else if (start) begin
        m_a = op_a; m_b = op_b; m_sub = sub_add;
        m_busy = 1'b1;
        m_cnt  = 0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    logic [7:0] ea, eb;
    ea = m_busy ? 8'(m_a >> (8 * m_cnt)) : 8'h00;
    eb = m_busy ? 8'(m_b >> (8 * m_cnt)) : 8'h00;
    chk("busy", 64'(busy), 64'(m_busy));
    chk("done", 64'(done), 64'(m_done));
    chk("result", 64'(result), 64'(m_res));
    chk("bc_out", 64'(bc_out), 64'(m_bc));
    chk("zero", 64'(zero), 64'(m_zero));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("add_a", 64'(add_a), 64'(ea));
    chk("add_b", 64'(add_b), 64'(eb));
    chk("add_sub_add", 64'(add_sub_add), 64'(m_busy & m_sub));
    chk("add_bcin", 64'(add_bcin),
        64'(m_busy ? chain_in(m_a, m_b, m_sub, m_cnt) : 1'b0));
  end

  // ---------------- directed stimulus ----------------
  // Called #1 after an edge while idle; returns #1 after the accepting edge
  task automatic start_op(input logic sub, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; sub_add = sub; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0; sub_add = ~sub; op_a = ~a; op_b = ~b;
  endtask

  task automatic wait_done(input bit intrude, output int cyc, output int busy_n,
                           output logic bcin1);
    cyc = 0; busy_n = 0; bcin1 = 1'b0;
    while (done !== 1'b1 && cyc < 20) begin
      if (busy === 1'b1) busy_n++;
      if (cyc == 1) bcin1 = add_bcin;
      if (intrude && cyc == 1) begin
        start = 1'b1; sub_add = 1'b1; op_a = 32'hFFFF_FFFF; op_b = 32'h0000_0001;
      end
      if (intrude && cyc == 2) start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    if (cyc >= 20) chk("done_timeout", 64'(cyc), 64'(NB));
  endtask

  task automatic run_op(input string name, input logic sub,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] er, input logic ebc,
                        input logic ez, input logic eo);
    int cyc, bn;
    logic b1;
    start_op(sub, a, b);
    wait_done(1'b0, cyc, bn, b1);
    chk({name, "_latency"}, 64'(cyc), 64'(NB));
    chk({name, "_busy_cycles"}, 64'(bn), 64'(NB));
    chk({name, "_result"}, 64'(result), 64'(er));
    chk({name, "_bc"}, 64'(bc_out), 64'(ebc));
    chk({name, "_zero"}, 64'(zero), 64'(ez));
    chk({name, "_ovf"}, 64'(ovf), 64'(eo));
  endtask

  initial begin
    int cyc, bn;
    logic b1;
    rst_n = 1'b1; start = 1'b0; sub_add = 1'b0; op_a = '0; op_b = '0;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_add_a", 64'(add_a), 64'd0);
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: carry out of byte 0 into byte 1
    start_op(1'b0, 32'h0000_00FF, 32'h0000_0001);
    wait_done(1'b0, cyc, bn, b1);
    chk("t1_latency", 64'(cyc), 64'd4);
    chk("t1_busy_cycles", 64'(bn), 64'd4);
    chk("t1_bcin_idx1", 64'(b1), 64'd1);
    chk("t1_result", 64'(result), 64'h0000_0100);
    chk("t1_flags", 64'({bc_out, zero, ovf}), 64'd0);

    // 2: full borrow chain
    run_op("t2", 1'b1, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    // 3: signed overflow, then full carry to zero
    run_op("t3a", 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    run_op("t3b", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    // 4: zero difference, then subtract overflow
    run_op("t4a", 1'b1, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
    run_op("t4b", 1'b1, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);

    // 5: START while busy is ignored; START in the DONE cycle is accepted
    start_op(1'b0, 32'h1111_1111, 32'h2222_2222);
    wait_done(1'b1, cyc, bn, b1);
    chk("t5_latency", 64'(cyc), 64'd4);
    chk("t5_result", 64'(result), 64'h3333_3333);
    chk("t5_flags", 64'({bc_out, zero, ovf}), 64'd0);
    start_op(1'b1, 32'h0000_0010, 32'h0000_0020);
    chk("t5_held_result", 64'(result), 64'h3333_3333);
    wait_done(1'b0, cyc, bn, b1);
    chk("t5b_latency", 64'(cyc), 64'd4);
    chk("t5b_result", 64'(result), 64'hFFFF_FFF0);
    chk("t5b_flags", 64'({bc_out, zero, ovf}), 64'b100);

    // 6: reset mid-operation clears everything before the next edge
    start_op(1'b0, 32'h5A5A_5A5A, 32'h0101_0101);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_done", 64'(done), 64'd0);
    chk("t6_result", 64'(result), 64'd0);
    chk("t6_flags", 64'({bc_out, zero, ovf}), 64'd0);
    chk("t6_stage", 64'({add_a, add_b, add_bcin, add_sub_add}), 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t6_no_done", 64'(done), 64'd0);
    end
    run_op("t6b", 1'b0, 32'h0102_0304, 32'h1020_3040, 32'h1122_3344, 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
